// File: rtl/node_input_loader.sv
// Serial-to-parallel operand loader for the neural node stage: gathers x[], w[] and bias words
// from a valid/ready stream. Optional macro LOADER_WEIGHT_HOLD_EN keeps nw/b across x-only frames.
module node_input_loader #(
   parameter int unsigned sx = 2,
   parameter int unsigned n  = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [n-1:0]    in_data,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            in_start,
   output logic [n*sx-1:0] nx,
   output logic [n*sx-1:0] nw,
   output logic [n-1:0]    b,
   output logic            out_valid,
   input  logic            out_ready
);

   typedef enum logic [1:0] {StLoadX, StLoadW, StLoadB, StFull} state_e;

   localparam int unsigned     IdxW    = (sx > 1) ? $clog2(sx) : 1;
   localparam logic [IdxW-1:0] IdxLast = IdxW'(sx - 1);

   state_e            state_q, state_d, st_eff;
   logic [IdxW-1:0]   idx_q, idx_d, idx_eff;
   logic              in_ready_q, out_valid_q;
   logic [n*sx-1:0]   nx_q, nw_q;
   logic [n-1:0]      b_q;
   logic              accept;
   logic              restart;
   logic              hold_w;

   assign accept  = in_valid && in_ready_q;
   assign restart = in_start && (state_q != StFull);

`ifdef LOADER_WEIGHT_HOLD_EN
   logic wload_q, wload_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wload_q <= 1'b0;
      end else begin
         wload_q <= wload_d;
      end
   end

   // A restart invalidates retained weights, so the frame in progress is a full reload.
   assign hold_w = wload_q && !restart;
`else
   assign hold_w = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StLoadX;
         idx_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         in_ready_q  <= (state_d != StFull);
         out_valid_q <= (state_d == StFull);
      end
   end

   // Next-state logic; a restart redirects the current accept to slot x[0].
   always_comb begin
      st_eff  = state_q;
      idx_eff = idx_q;
      if (restart) begin
         st_eff  = StLoadX;
         idx_eff = '0;
      end
      state_d = st_eff;
      idx_d   = idx_eff;
`ifdef LOADER_WEIGHT_HOLD_EN
      wload_d = hold_w;
`endif
      unique case (st_eff)
         StLoadX: begin
            if (accept) begin
               if (idx_eff == IdxLast) begin
                  idx_d   = '0;
                  state_d = hold_w ? StFull : StLoadW;
               end else begin
                  idx_d = idx_eff + 1'b1;
               end
            end
         end
         StLoadW: begin
            if (accept) begin
               if (idx_eff == IdxLast) begin
                  idx_d   = '0;
                  state_d = StLoadB;
               end else begin
                  idx_d = idx_eff + 1'b1;
               end
            end
         end
         StLoadB: begin
            if (accept) begin
               idx_d   = '0;
               state_d = StFull;
`ifdef LOADER_WEIGHT_HOLD_EN
               wload_d = 1'b1;
`endif
            end
         end
         StFull: begin
            if (out_valid_q && out_ready) begin
               state_d = StLoadX;
               idx_d   = '0;
            end
         end
         default: begin
            state_d = StLoadX;
            idx_d   = '0;
         end
      endcase
   end

   // Operand registers only move on an accept edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nx_q <= '0;
         nw_q <= '0;
         b_q  <= '0;
      end else if (accept) begin
         unique case (st_eff)
            StLoadX: nx_q[idx_eff*n +: n] <= in_data;
            StLoadW: nw_q[idx_eff*n +: n] <= in_data;
            StLoadB: b_q                  <= in_data;
            default: ;
         endcase
      end
   end

   // Outputs
   always_comb begin
      nx        = nx_q;
      nw        = nw_q;
      b         = b_q;
      in_ready  = in_ready_q;
      out_valid = out_valid_q;
   end

endmodule

// File: tb/tb_node_input_loader.sv
// Directed bench for node_input_loader (default build, sx=2, n=32): frame assembly,
// handshakes, restart, FULL hold and asynchronous reset.
module tb_node_input_loader;

  localparam int unsigned SX = 2;
  localparam int unsigned N  = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_start;
  logic [N*SX-1:0] nx;
  logic [N*SX-1:0] nw;
  logic [N-1:0]    b;
  logic            out_valid;
  logic            out_ready;

  int vectors = 0;
  int errs    = 0;
  int acc     = 0;

  node_input_loader #(.sx(SX), .n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .nx        (nx),
    .nw        (nw),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst && in_valid && in_ready) acc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N-1:0] w);
    in_data  = w;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_start  = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    vectors++;
    if (nx !== 64'h0) begin errs++; $error("FAIL rst_nx: got %0h want 0", nx); end
    vectors++;
    if (nw !== 64'h0) begin errs++; $error("FAIL rst_nw: got %0h want 0", nw); end
    vectors++;
    if (b !== 32'h0) begin errs++; $error("FAIL rst_b: got %0h want 0", b); end
    vectors++;
    if (out_valid !== 1'b0) begin errs++; $error("FAIL rst_ovalid: got %0b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b0) begin errs++; $error("FAIL rst_iready: got %0b want 0", in_ready); end
    rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin errs++; $error("FAIL rel_iready: got %0b want 1", in_ready); end

    // Frame 1: back-to-back, consumer stalled
    send(32'h01000000);
    send(32'hFD000000);
    send(32'h00800000);
    send(32'h00100000);
    send(32'h02000000);
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL f1_ovalid: got %0b want 1", out_valid); end
    vectors++;
    if (in_ready !== 1'b0) begin errs++; $error("FAIL f1_iready: got %0b want 0", in_ready); end
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    repeat (10) tick();
    in_valid = 1'b0;
    vectors++;
    if (acc != 5) begin errs++; $error("FAIL f1_accepts: got %0d want 5", acc); end
    vectors++;
    if (nx !== {32'hFD000000, 32'h01000000}) begin
      errs++; $error("FAIL f1_nx: got %0h", nx);
    end
    vectors++;
    if (nw !== {32'h00100000, 32'h00800000}) begin
      errs++; $error("FAIL f1_nw: got %0h", nw);
    end
    vectors++;
    if (b !== 32'h02000000) begin errs++; $error("FAIL f1_b: got %0h", b); end
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL f1_hold_ovalid: got %0b", out_valid); end

    // Frame 2: one-cycle out_ready, in_valid toggling
    handoff();
    vectors++;
    if (out_valid !== 1'b0) begin errs++; $error("FAIL ho_ovalid: got %0b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b1) begin errs++; $error("FAIL ho_iready: got %0b want 1", in_ready); end
    send(32'h00400000); tick();
    send(32'hFF800000); tick();
    send(32'h00C00000); tick();
    send(32'hFFF00000); tick();
    vectors++;
    if (out_valid !== 1'b0) begin errs++; $error("FAIL f2_pre_ovalid: got %0b", out_valid); end
    send(32'h01800000);
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL f2_ovalid: got %0b want 1", out_valid); end
    vectors++;
    if (acc != 10) begin errs++; $error("FAIL f2_accepts: got %0d want 10", acc); end
    vectors++;
    if (nx !== {32'hFF800000, 32'h00400000}) begin
      errs++; $error("FAIL f2_nx: got %0h", nx);
    end
    vectors++;
    if (nw !== {32'hFFF00000, 32'h00C00000}) begin
      errs++; $error("FAIL f2_nw: got %0h", nw);
    end
    vectors++;
    if (b !== 32'h01800000) begin errs++; $error("FAIL f2_b: got %0h", b); end

    // Frame 3: restart after three words
    handoff();
    send(32'h11111111);
    send(32'h22222222);
    send(32'h33333333);
    in_start = 1'b1;
    send(32'h05000000);
    in_start = 1'b0;
    send(32'h06000000);
    send(32'h07000000);
    send(32'h08000000);
    vectors++;
    if (out_valid !== 1'b0) begin errs++; $error("FAIL f3_pre_ovalid: got %0b", out_valid); end
    send(32'h09000000);
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL f3_ovalid: got %0b want 1", out_valid); end
    vectors++;
    if (nx !== {32'h06000000, 32'h05000000}) begin
      errs++; $error("FAIL f3_nx: got %0h", nx);
    end
    vectors++;
    if (nw !== {32'h08000000, 32'h07000000}) begin
      errs++; $error("FAIL f3_nw: got %0h", nw);
    end
    vectors++;
    if (b !== 32'h09000000) begin errs++; $error("FAIL f3_b: got %0h", b); end

    // in_start while FULL must not disturb the presented set
    in_start = 1'b1;
    send(32'hCAFEF00D);
    in_start = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL full_start_ovalid: got %0b", out_valid); end
    vectors++;
    if (nx !== {32'h06000000, 32'h05000000}) begin
      errs++; $error("FAIL full_start_nx: got %0h", nx);
    end
    vectors++;
    if (b !== 32'h09000000) begin errs++; $error("FAIL full_start_b: got %0h", b); end

    // Asynchronous reset mid-frame
    handoff();
    send(32'hAAAAAAAA);
    send(32'hBBBBBBBB);
    rst = 1'b0;
    #3;
    vectors++;
    if (nx !== 64'h0) begin errs++; $error("FAIL arst_nx: got %0h want 0", nx); end
    vectors++;
    if (nw !== 64'h0) begin errs++; $error("FAIL arst_nw: got %0h want 0", nw); end
    vectors++;
    if (b !== 32'h0) begin errs++; $error("FAIL arst_b: got %0h want 0", b); end
    vectors++;
    if (out_valid !== 1'b0) begin errs++; $error("FAIL arst_ovalid: got %0b want 0", out_valid); end
    vectors++;
    if (in_ready !== 1'b0) begin errs++; $error("FAIL arst_iready: got %0b want 0", in_ready); end
    rst = 1'b1;
    tick();
    vectors++;
    if (in_ready !== 1'b1) begin errs++; $error("FAIL arst_rel_iready: got %0b", in_ready); end
    send(32'h0A000000);
    send(32'h0B000000);
    send(32'h0C000000);
    send(32'h0D000000);
    send(32'h0E000000);
    vectors++;
    if (out_valid !== 1'b1) begin errs++; $error("FAIL f4_ovalid: got %0b want 1", out_valid); end
    vectors++;
    if (nx !== {32'h0B000000, 32'h0A000000}) begin
      errs++; $error("FAIL f4_nx: got %0h", nx);
    end
    vectors++;
    if (nw !== {32'h0D000000, 32'h0C000000}) begin
      errs++; $error("FAIL f4_nw: got %0h", nw);
    end
    vectors++;
    if (b !== 32'h0E000000) begin errs++; $error("FAIL f4_b: got %0h", b); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/node_input_loader.md
Name: node_input_loader

Overview:
- Upstream feeder for the neural `node` stage.
- Accepts a serial stream of n-bit fixed-point words over a valid/ready handshake and assembles them into the node's parallel operands: nx (sx inputs concatenated), nw (sx weights concatenated) and b (bias).
- Presents each complete operand set under a valid/ready handshake and holds it stable until the node side accepts it.

Parameters:
- sx, 2, number of x/w pairs per node.
- n, `n (32), word width in bits.
- f, `f (24), fraction bits; used by the bench only, no arithmetic inside the block.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; one clock, asynchronous, active-low.
- in_data  in  n  signed word (x, w or b, per sequence).
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a word.
- in_start  in  1  frame restart; abort the partial frame.
- nx  out  n*sx  x[j] at nx[j*n +: n].
- nw  out  n*sx  w[j] at nw[j*n +: n].
- b  out  n  bias.
- out_valid  out  1  nx/nw/b complete and stable.
- out_ready  in  1  consumer takes the operand set.

Behaviour:
- Reset (rst=0, asynchronous): nx=0, nw=0, b=0, out_valid=0, in_ready=0, state=LOAD_X, idx=0.
- Release of reset: in_ready=1 from the first clk edge after rst=1.
- A word is accepted on a rising edge with in_valid && in_ready.
- Frame order: x[0]..x[sx-1], then w[0]..w[sx-1], then b. Total 2*sx+1 words.
- Index counter idx: 0..sx-1, clears when its state changes.
- State machine:
  - LOAD_X: accepted word goes to nx[idx*n +: n]. At idx=sx-1, go to LOAD_W.
  - LOAD_W: accepted word goes to nw[idx*n +: n]. At idx=sx-1, go to LOAD_B.
  - LOAD_B: accepted word goes to b. Go to FULL; out_valid=1 in the cycle after the accept edge.
  - FULL: in_ready=0; nx/nw/b held. On out_valid && out_ready: out_valid=0, in_ready=1, go to LOAD_X. One bubble cycle; no word is accepted in the handoff cycle.
- in_ready is registered and equals 1 in every LOAD_* state.
- Output registers change only on an accept edge. Partially loaded frames overwrite slots in place; consumers sample only while out_valid=1.
- in_start=1 on an edge in any LOAD_* state: state=LOAD_X, idx=0.
  - If in_valid also accepted on that edge, in_data is taken as x[0] and idx becomes 1.
- in_start in FULL: ignored, so the presented set is never corrupted.
- No sign extension or rounding; words are stored bit-exact.
- Reset mid-frame or mid-FULL: all state and outputs clear immediately; out_valid drops asynchronously.

Optional Feature:
- Macro: LOADER_WEIGHT_HOLD_EN.
- Defined:
  - After the first complete frame, subsequent frames carry only sx x words.
  - At x[sx-1] accept, go directly LOAD_X -> FULL; nw and b are retained.
  - in_start forces the next frame to be a full 2*sx+1-word reload.
  - Reset clears the "weights loaded" flag.
- Undefined: every frame is the full 2*sx+1-word sequence as above; in_start only restarts the frame.

Test Plan:
1. Reset, then feed 0x01000000, 0xFD000000, 0x00800000, 0x00100000, 0x02000000 back-to-back with out_ready=0 -> exactly 5 accepts; nx={0xFD000000,0x01000000}, nw={0x00100000,0x00800000}, b=0x02000000; out_valid=1, in_ready=0, and all values hold for 10 cycles.
2. Pulse out_ready=1 for one cycle -> out_valid=0 and in_ready=1 on the next edge; a second frame of 5 words with in_valid toggling every other cycle -> new nx/nw/b and out_valid=1 one cycle after the 5th accept.
3. After 3 words, assert in_start together with in_valid on word 0x05000000 -> it becomes x[0]; 4 more words complete the frame; b is the last word sent.
4. Assert rst=0 for 3 ns between clock edges mid-frame -> nx/nw/b/out_valid clear immediately; the next frame loads from x[0].
5. Random x/w/b in ±5.0 (`$random % (5<<f)`), 10 frames driven into a live `node` -> y matches the real-valued sigmoid reference within 2^-f·4.
6. With LOADER_WEIGHT_HOLD_EN: one full frame, then 2-word frames {0x00400000, 0x00C00000} -> FULL after 2 accepts with nw/b unchanged; in_start then requires 5 words.
